// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/usr_if.sv
// Control/data bundle of the universal shift register; master drives, slave is the register.
// Handshake: Start is sampled only while Busy=0; a burst runs while Busy=1 and ends
// with a one-cycle Done (never together with Busy); ParallelLoad aborts without Done.
interface usr_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  import usr_pkg::*;

  logic             ParallelLoad;
  logic             ShiftLeft;
  logic             ShiftRight;
  logic             Rotate;
  logic             ShiftInput;
  logic [WIDTH-1:0] Data;
  logic             Start;
  logic             Direction;
  logic [CNT_W-1:0] Count;
  logic [WIDTH-1:0] dataBus;
  logic             ShiftOutput;
  logic             Busy;
  logic             Done;
  state_t           fsmState;

  modport master (
    output ParallelLoad, ShiftLeft, ShiftRight, Rotate, ShiftInput, Data,
           Start, Direction, Count,
    input  dataBus, ShiftOutput, Busy, Done, fsmState
  );

  modport slave (
    input  ParallelLoad, ShiftLeft, ShiftRight, Rotate, ShiftInput, Data,
           Start, Direction, Count,
    output dataBus, ShiftOutput, Busy, Done, fsmState
  );

endinterface

// File: rtl/usr_shift_step.sv
// Combinational one-position shifter shared by manual and burst shifts.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             direction,
  input  logic             rotate,
  input  logic             shiftInput,
  output logic [WIDTH-1:0] nextValue,
  output logic             outBit
);

  logic fill;

  always_comb begin
    outBit    = 1'b0;
    fill      = 1'b0;
    nextValue = value;
    if (direction == DIR_LEFT) begin
      outBit    = value[WIDTH-1];
      fill      = rotate ? outBit : shiftInput;
      nextValue = {value[WIDTH-2:0], fill};
    end else begin
      outBit    = value[0];
      fill      = rotate ? outBit : shiftInput;
      nextValue = {fill, value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Width-configurable shift register with load, manual shift/rotate and a counted burst engine.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic clockPulse,
  input logic Reset,
  usr_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, nextState;
  logic [WIDTH-1:0] dataReg, dataNext;
  logic             shiftOutReg, shiftOutNext;
  logic             doneReg, doneNext;
  logic [CNT_W-1:0] remaining, remainingNext;
  logic             latchedDir, latchedDirNext;

  logic             stepDir;
  logic [WIDTH-1:0] stepValue;
  logic             stepOut;

  // Burst direction is frozen at Start; manual shifts resolve left-over-right.
  assign stepDir = (state == BURST) ? latchedDir
                 : (bus.ShiftLeft ? DIR_LEFT : DIR_RIGHT);

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (dataReg),
    .direction  (stepDir),
    .rotate     (bus.Rotate),
    .shiftInput (bus.ShiftInput),
    .nextValue  (stepValue),
    .outBit     (stepOut)
  );

  always_ff @(posedge clockPulse or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      dataReg     <= '0;
      shiftOutReg <= 1'b0;
      doneReg     <= 1'b0;
      remaining   <= '0;
      latchedDir  <= DIR_LEFT;
    end else begin
      state       <= nextState;
      dataReg     <= dataNext;
      shiftOutReg <= shiftOutNext;
      doneReg     <= doneNext;
      remaining   <= remainingNext;
      latchedDir  <= latchedDirNext;
    end
  end

  always_comb begin
    nextState      = state;
    dataNext       = dataReg;
    shiftOutNext   = shiftOutReg;
    doneNext       = 1'b0;
    remainingNext  = remaining;
    latchedDirNext = latchedDir;
    case (state)
      IDLE: begin
        if (bus.ParallelLoad) begin
          dataNext     = bus.Data;
          shiftOutNext = 1'b0;
        end else if (bus.Start) begin
          latchedDirNext = bus.Direction;
          remainingNext  = bus.Count;
          if (bus.Count != '0) nextState = BURST;
          else                 doneNext  = 1'b1;
        end else if (bus.ShiftLeft || bus.ShiftRight) begin
          dataNext     = stepValue;
          shiftOutNext = stepOut;
        end
      end
      BURST: begin
        if (bus.ParallelLoad) begin
          dataNext      = bus.Data;
          shiftOutNext  = 1'b0;
          remainingNext = '0;
          nextState     = IDLE;
        end else begin
          dataNext      = stepValue;
          shiftOutNext  = stepOut;
          remainingNext = remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            nextState = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.dataBus     = dataReg;
  assign bus.ShiftOutput = shiftOutReg;
  assign bus.Busy        = (state == BURST);
  assign bus.Done        = doneReg;
  assign bus.fsmState    = state;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench: behavioural model checked every cycle plus hand-computed literal checks.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic clockPulse = 1'b0;
  logic Reset      = 1'b0;
  logic checkEn    = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  usr_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clockPulse (clockPulse),
    .Reset      (Reset),
    .bus        (bus)
  );

  // clock
  always #5 clockPulse = ~clockPulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register as an integer, shifts as arithmetic.
  logic [W+2:0] exp_q[$];
  int mData, mSo, mBusy, mDone, mLeft, mDir;

  function automatic void modelStep(input int dir);
    int outb, fillb;
    if (dir == 0) begin
      outb  = (mData >> (W - 1)) & 1;
      fillb = bus.Rotate ? outb : int'(bus.ShiftInput);
      mData = ((mData << 1) | fillb) & ((1 << W) - 1);
    end else begin
      outb  = mData & 1;
      fillb = bus.Rotate ? outb : int'(bus.ShiftInput);
      mData = (mData >> 1) | (fillb << (W - 1));
    end
    mSo = outb;
  endfunction

  always @(posedge clockPulse or negedge Reset) begin
    logic [W-1:0] d;
    if (!Reset) begin
      mData = 0; mSo = 0; mBusy = 0; mDone = 0; mLeft = 0; mDir = 0;
      exp_q.delete();
    end else begin
      mDone = 0;
      if (mBusy == 0) begin
        if (bus.ParallelLoad) begin
          mData = int'(bus.Data); mSo = 0;
        end else if (bus.Start) begin
          mDir  = int'(bus.Direction);
          mLeft = int'(bus.Count);
          if (mLeft == 0) mDone = 1;
          else            mBusy = 1;
        end else if (bus.ShiftLeft) modelStep(0);
        else if (bus.ShiftRight)    modelStep(1);
      end else begin
        if (bus.ParallelLoad) begin
          mData = int'(bus.Data); mSo = 0; mBusy = 0; mLeft = 0;
        end else begin
          modelStep(mDir);
          mLeft--;
          if (mLeft == 0) begin mBusy = 0; mDone = 1; end
        end
      end
    end
    d = mData[W-1:0];
    exp_q.push_back({d, mSo[0], mBusy[0], mDone[0]});
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clockPulse) begin
    logic [W+2:0] e;
    if (checkEn && exp_q.size() > 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      e = exp_q.pop_front();
      chk("model dataBus", 32'(bus.dataBus), 32'(e[W+2:3]));
      chk("model ShiftOutput", 32'(bus.ShiftOutput), 32'(e[2]));
      chk("model Busy", 32'(bus.Busy), 32'(e[1]));
      chk("model Done", 32'(bus.Done), 32'(e[0]));
      chk("model fsmState", 32'(bus.fsmState == BURST), 32'(e[1]));
      chk("Busy/Done exclusive", 32'(bus.Busy & bus.Done), 32'd0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clockPulse);
    #2;
  endtask

  task automatic idleInputs();
    bus.ParallelLoad = 1'b0; bus.ShiftLeft = 1'b0; bus.ShiftRight = 1'b0;
    bus.Rotate = 1'b0; bus.ShiftInput = 1'b0; bus.Data = '0;
    bus.Start = 1'b0; bus.Direction = 1'b0; bus.Count = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.ParallelLoad = 1'b1; bus.Data = v;
    tick();
    bus.ParallelLoad = 1'b0;
  endtask

  task automatic expect4(input string name, input logic [W-1:0] d, input logic so,
                         input logic busy, input logic done);
    chk({name, " dataBus"}, 32'(bus.dataBus), 32'(d));
    chk({name, " ShiftOutput"}, 32'(bus.ShiftOutput), 32'(so));
    chk({name, " Busy"}, 32'(bus.Busy), 32'(busy));
    chk({name, " Done"}, 32'(bus.Done), 32'(done));
  endtask

  initial begin
    idleInputs();
    Reset = 1'b0;
    tick(); tick();
    expect4("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset fsmState", 32'(bus.fsmState), 32'(IDLE));
    Reset = 1'b1;
    checkEn = 1'b1;

    load(4'b1010);
    expect4("load 1010", 4'b1010, 1'b0, 1'b0, 1'b0);
    bus.ShiftLeft = 1'b1; bus.ShiftInput = 1'b0;
    tick();
    bus.ShiftLeft = 1'b0;
    expect4("shl fill0", 4'b0100, 1'b1, 1'b0, 1'b0);

    load(4'b1010);
    bus.ShiftLeft = 1'b1; bus.ShiftRight = 1'b1; bus.ShiftInput = 1'b1;
    tick();
    expect4("left wins", 4'b0101, 1'b1, 1'b0, 1'b0);
    bus.ShiftLeft = 1'b0; bus.Rotate = 1'b1;
    tick();
    expect4("rotr", 4'b1010, 1'b1, 1'b0, 1'b0);
    idleInputs();

    // burst left by 3
    load(4'b0001);
    bus.Start = 1'b1; bus.Direction = DIR_LEFT; bus.Count = 3'd3;
    tick();
    bus.Start = 1'b0;
    expect4("burst accept", 4'b0001, 1'b0, 1'b1, 1'b0);
    tick(); expect4("burst s1", 4'b0010, 1'b0, 1'b1, 1'b0);
    tick(); expect4("burst s2", 4'b0100, 1'b0, 1'b1, 1'b0);
    tick(); expect4("burst done", 4'b1000, 1'b0, 1'b0, 1'b1);
    tick(); expect4("burst after", 4'b1000, 1'b0, 1'b0, 1'b0);

    // burst right rotate by 6 wraps
    load(4'b1001);
    bus.Start = 1'b1; bus.Direction = DIR_RIGHT; bus.Rotate = 1'b1; bus.Count = 3'd6;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot6 busy", 32'(bus.Busy), 32'd1);
    end
    tick();
    expect4("rot6 done", 4'b0110, 1'b0, 1'b0, 1'b1);
    idleInputs();

    // ignored controls during burst, then abort by load
    load(4'b0011);
    bus.Start = 1'b1; bus.Direction = DIR_LEFT; bus.Count = 3'd5;
    tick();
    bus.Start = 1'b0;
    tick();
    expect4("abort s1", 4'b0110, 1'b0, 1'b1, 1'b0);
    bus.ShiftLeft = 1'b1; bus.Start = 1'b1; bus.Direction = DIR_RIGHT; bus.Count = 3'd2;
    tick();
    expect4("ignored", 4'b1100, 1'b0, 1'b1, 1'b0);
    idleInputs();
    load(4'b1111);
    expect4("abort load", 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    expect4("abort no done", 4'b1111, 1'b0, 1'b0, 1'b0);

    // zero-count burst
    bus.Start = 1'b1; bus.Count = 3'd0;
    tick();
    bus.Start = 1'b0;
    expect4("count0", 4'b1111, 1'b0, 1'b0, 1'b1);
    tick();
    expect4("count0 after", 4'b1111, 1'b0, 1'b0, 1'b0);

    // async reset mid-burst
    bus.Start = 1'b1; bus.Direction = DIR_RIGHT; bus.Count = 3'd7; bus.ShiftInput = 1'b0;
    tick();
    bus.Start = 1'b0;
    tick();
    expect4("pre reset", 4'b0111, 1'b1, 1'b1, 1'b0);
    Reset = 1'b0;
    #1;
    expect4("async reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("async reset fsmState", 32'(bus.fsmState), 32'(IDLE));
    tick();
    Reset = 1'b1;
    tick();
    expect4("post reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // back-to-back one-position bursts
    bus.Start = 1'b1; bus.Direction = DIR_LEFT; bus.Count = 3'd1; bus.ShiftInput = 1'b1;
    tick(); expect4("b2b accept1", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick(); expect4("b2b done1", 4'b0001, 1'b0, 1'b0, 1'b1);
    tick(); expect4("b2b accept2", 4'b0001, 1'b0, 1'b1, 1'b0);
    bus.Start = 1'b0;
    tick(); expect4("b2b done2", 4'b0011, 1'b0, 1'b0, 1'b1);
    idleInputs();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
